booth_multiplier_param: RTL and testbench
=========================================

// Module: booth_multiplier_param
// PURPOSE
//  Parametrised sequential Booth multiplier, next generation of the 4-bit start/busy multiplier.
//  Adds generic width, radix-2/radix-4 recoding, run-time signed/unsigned select, sync reset and done pulse.
//  Sits on the arithmetic datapath beside the existing multiplier; same start/busy handshake style.
// PARAMETERS
//  WIDTH   8   operand width in bits, >= 2
//  RADIX4  1   0: radix-2 Booth, one multiplier bit per cycle; 1: radix-4 Booth, two bits per cycle
// PORTS
//  clock         in   1         single clock, all state on rising edge
//  reset         in   1         synchronous, active-high
//  start         in   1         request; sampled only in IDLE
//  signed_mode   in   1         1: operands two's complement; 0: unsigned; sampled with start
//  multiplicand  in   WIDTH     operand A, sampled with start
//  multiplier    in   WIDTH     operand B, sampled with start
//  product       out  2*WIDTH   result register; held until next accepted start
//  busy          out  1         high while operation in progress
//  done          out  1         one-cycle pulse, product valid
// BEHAVIOUR
//  Reset (sync, active-high): state=IDLE; product=0; busy=0; done=0; internal regs cleared.
//  Reset has priority over every other input. Reset mid-operation aborts it, with no done pulse.
//  Width rule: operands are extended to E=WIDTH+1 bits, sign-extended if signed_mode, else zero-extended.
//  - RADIX4=1: the extended multiplier is further sign-extended to even width.
//  - The accumulator is wide enough for the full extended product.
//  - product = low 2*WIDTH bits, which is exact for both modes, all operand values.
//  Iterations N: RADIX4=0 -> N=WIDTH+1; RADIX4=1 -> N=ceil((WIDTH+1)/2). WIDTH=4 gives 5 and 3.
//  Recoding: radix-2 uses {b(i),b(i-1)} -> 0,+A,-A. Radix-4 uses {b(2i+1),b(2i),b(2i-1)} -> 0,+-A,+-2A.
//  - b(-1)=0 in both. -A and -2A are formed in accumulator width, with no overflow.
//  States: IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: if start, latch operands and signed_mode, clear accumulator and counter, go RUN. busy=1 from the next cycle.
//  - RUN: one recode/add/arithmetic-shift step per clock. After step N, write product and go DONE.
//  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
//  Latency: start sampled at edge k; busy high after edges k..k+N; product updated and done=1 after edge k+N+1.
//  busy and done are never high together. busy=0 in IDLE and DONE.
//  start while busy or in DONE: ignored, with no effect on the operation in flight. Operands may change freely while busy.
//  Back-to-back: start held high is accepted on the first IDLE cycle after DONE.
//  product holds its last value across IDLE and RUN, changing only at the DONE-entry edge or reset.
// TESTING  (WIDTH=4 unless stated; run every case with RADIX4=0 and RADIX4=1)
//  1 unsigned A=4'b1100 B=4'b1011 start 1 cycle -> product=8'h84 (132), done after N+1 edges (6 / 4).
//  2 signed   A=4'b1100 B=4'b1011 -> product=8'h14 (+20). Also A=4'b1000 B=4'b1000 -> 8'h40 (+64).
//  3 boundaries -> unsigned 15*15=8'hE1; signed -8*7=8'hC8; signed -1*-1=8'h01; any*0=8'h00.
//  4 start pulses and operand changes while busy -> ignored, result from the first operands, one done pulse only.
//  5 reset asserted in 2nd RUN cycle -> next cycle busy=0, done=0, product=0, and the next start runs normally.
//  6 WIDTH=8, 1000 random operands x both modes, start held high back-to-back -> product equals reference A*B, one done per op.

Source files
------------

// File: rtl/booth_multiplier_param_if.sv
// Handshake and operand/result bundle for the sequential Booth multiplier.
// The requester drives the master side; the multiplier sits on the slave side.
interface booth_multiplier_param_if #(
   parameter int WIDTH = 8
);
   logic                 start;
   logic                 signed_mode;
   logic [WIDTH-1:0]     multiplicand;
   logic [WIDTH-1:0]     multiplier;
   logic [2*WIDTH-1:0]   product;
   logic                 busy;
   logic                 done;

   modport master (
      output start, signed_mode, multiplicand, multiplier,
      input  product, busy, done
   );

   modport slave (
      input  start, signed_mode, multiplicand, multiplier,
      output product, busy, done
   );
endinterface

// File: rtl/booth_multiplier_param.sv
// Sequential radix-2 / radix-4 Booth multiplier with run-time signed/unsigned select,
// start/busy handshake and a one-cycle done pulse.
module booth_multiplier_param #(
   parameter int WIDTH  = 8,
   parameter int RADIX4 = 1
) (
   input  logic clock,
   input  logic reset,
   booth_multiplier_param_if.slave bus
);
   localparam int E  = WIDTH + 1;
   localparam int M  = (RADIX4 != 0) ? E + (E % 2) : E;
   localparam int HW = E + 2;
   localparam int N  = (RADIX4 != 0) ? M / 2 : E;
   localparam int CW = $clog2(N + 1);
   localparam int PW = 2 * WIDTH;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t               state;
   logic signed [HW-1:0] a_ext;
   logic signed [HW-1:0] hi;
   logic        [M-1:0]  lo;
   logic                 lo_m1;
   logic        [CW-1:0] cnt;

   logic signed [HW-1:0] pp;
   logic signed [HW-1:0] hi_sum;
   logic signed [HW-1:0] hi_nx;
   logic        [M-1:0]  lo_nx;
   logic                 lo_m1_nx;

   function automatic logic signed [HW-1:0] extend_a(input logic [WIDTH-1:0] v,
                                                     input logic sm);
      extend_a = {{(HW-WIDTH){sm & v[WIDTH-1]}}, v};
   endfunction

   function automatic logic [M-1:0] extend_b(input logic [WIDTH-1:0] v, input logic sm);
      extend_b = {{(M-WIDTH){sm & v[WIDTH-1]}}, v};
   endfunction

   // The accumulator has two guard bits over the extended operand, so +-2A never overflows.
   function automatic logic signed [HW-1:0] recode(input logic [2:0] c,
                                                   input logic signed [HW-1:0] a);
      logic signed [HW-1:0] two_a;
      two_a  = a <<< 1;
      recode = '0;
      if (RADIX4 != 0) begin
         case (c)
            3'b001, 3'b010: recode = a;
            3'b011:         recode = two_a;
            3'b100:         recode = -two_a;
            3'b101, 3'b110: recode = -a;
            default:        recode = '0;
         endcase
      end else begin
         case (c[1:0])
            2'b01:   recode = a;
            2'b10:   recode = -a;
            default: recode = '0;
         endcase
      end
   endfunction

   always_comb begin
      pp     = recode({lo[1:0], lo_m1}, a_ext);
      hi_sum = hi + pp;
      if (RADIX4 != 0) begin
         hi_nx    = hi_sum >>> 2;
         lo_nx    = {hi_sum[1:0], lo[M-1:2]};
         lo_m1_nx = lo[1];
      end else begin
         hi_nx    = hi_sum >>> 1;
         lo_nx    = {hi_sum[0], lo[M-1:1]};
         lo_m1_nx = lo[0];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         bus.product <= '0;
         bus.busy    <= 1'b0;
         bus.done    <= 1'b0;
         a_ext       <= '0;
         hi          <= '0;
         lo          <= '0;
         lo_m1       <= 1'b0;
         cnt         <= '0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a_ext    <= extend_a(bus.multiplicand, bus.signed_mode);
                  lo       <= extend_b(bus.multiplier, bus.signed_mode);
                  hi       <= '0;
                  lo_m1    <= 1'b0;
                  cnt      <= '0;
                  bus.busy <= 1'b1;
                  state    <= RUN;
               end
            end
            RUN: begin
               // One extra RUN cycle after the last step publishes the result.
               if (cnt == CW'(N)) begin
                  bus.product <= PW'({hi, lo});
                  bus.busy    <= 1'b0;
                  bus.done    <= 1'b1;
                  state       <= DONE;
               end else begin
                  hi    <= hi_nx;
                  lo    <= lo_nx;
                  lo_m1 <= lo_m1_nx;
                  cnt   <= cnt + CW'(1);
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_booth_multiplier_param.sv
// Directed bench for booth_multiplier_param: WIDTH=4 and WIDTH=8, each in radix-2 and radix-4.
module tb_booth_multiplier_param;
   logic clock = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clock = ~clock;

   booth_multiplier_param_if #(.WIDTH(4)) b4r2 ();
   booth_multiplier_param_if #(.WIDTH(4)) b4r4 ();
   booth_multiplier_param_if #(.WIDTH(8)) b8r2 ();
   booth_multiplier_param_if #(.WIDTH(8)) b8r4 ();

   booth_multiplier_param #(.WIDTH(4), .RADIX4(0)) u_4r2 (.clock(clock), .reset(reset), .bus(b4r2));
   booth_multiplier_param #(.WIDTH(4), .RADIX4(1)) u_4r4 (.clock(clock), .reset(reset), .bus(b4r4));
   booth_multiplier_param #(.WIDTH(8), .RADIX4(0)) u_8r2 (.clock(clock), .reset(reset), .bus(b8r2));
   booth_multiplier_param #(.WIDTH(8), .RADIX4(1)) u_8r4 (.clock(clock), .reset(reset), .bus(b8r4));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive4(input logic st, input logic sm, input logic [3:0] a, input logic [3:0] b);
      b4r2.start = st; b4r2.signed_mode = sm; b4r2.multiplicand = a; b4r2.multiplier = b;
      b4r4.start = st; b4r4.signed_mode = sm; b4r4.multiplicand = a; b4r4.multiplier = b;
   endtask

   task automatic drive8(input int r, input logic st, input logic sm,
                         input logic [7:0] a, input logic [7:0] b);
      if (r == 0) begin
         b8r2.start = st; b8r2.signed_mode = sm; b8r2.multiplicand = a; b8r2.multiplier = b;
      end else begin
         b8r4.start = st; b8r4.signed_mode = sm; b8r4.multiplicand = a; b8r4.multiplier = b;
      end
   endtask

   function automatic logic done8(input int r);
      return (r == 0) ? b8r2.done : b8r4.done;
   endfunction

   function automatic logic [15:0] product8(input int r);
      return (r == 0) ? b8r2.product : b8r4.product;
   endfunction

   // One WIDTH=4 operation on both radices; optionally pokes start and operands while busy.
   task automatic run4(input string tag, input logic sm, input logic [3:0] a, input logic [3:0] b,
                       input logic [7:0] exp, input bit disturb);
      int d2, d4, n2, n4;
      logic [7:0] p2, p4;
      d2 = -1; d4 = -1; n2 = 0; n4 = 0; p2 = '0; p4 = '0;
      @(negedge clock);
      drive4(1'b1, sm, a, b);
      @(negedge clock);
      drive4(1'b0, sm, a, b);
      check({tag, "_busy_r2"}, 32'(b4r2.busy), 32'd1);
      check({tag, "_busy_r4"}, 32'(b4r4.busy), 32'd1);
      for (int c = 1; c <= 12; c++) begin
         @(negedge clock);
         if (b4r2.done) begin
            n2++;
            if (d2 < 0) begin d2 = c; p2 = b4r2.product; end
         end
         if (b4r4.done) begin
            n4++;
            if (d4 < 0) begin d4 = c; p4 = b4r4.product; end
         end
         if (disturb) drive4((c == 1) || (c == 4), ~sm, 4'hf, 4'hf);
      end
      drive4(1'b0, sm, a, b);
      check({tag, "_lat_r2"}, 32'(d2), 32'd6);
      check({tag, "_lat_r4"}, 32'(d4), 32'd4);
      check({tag, "_prod_r2"}, 32'(p2), 32'(exp));
      check({tag, "_prod_r4"}, 32'(p4), 32'(exp));
      check({tag, "_ndone_r2"}, 32'(n2), 32'd1);
      check({tag, "_ndone_r4"}, 32'(n4), 32'd1);
      check({tag, "_hold_r2"}, 32'(b4r2.product), 32'(exp));
      check({tag, "_hold_r4"}, 32'(b4r4.product), 32'(exp));
   endtask

   // Back-to-back WIDTH=8 operations with start held high, alternating signed/unsigned.
   task automatic run8(input int r);
      int  last, cyc, per;
      bit  got;
      logic [7:0] a, b;
      logic sm;
      logic signed [15:0] sa, sb;
      logic [15:0] ua, ub, exp;
      per  = (r == 0) ? 12 : 8;
      last = -1;
      cyc  = 0;
      for (int i = 0; i < 2000; i++) begin
         a  = 8'($urandom);
         b  = 8'($urandom);
         sm = i[0];
         sa = $signed(a); sb = $signed(b);
         ua = 16'(a);     ub = 16'(b);
         exp = sm ? 16'(sa * sb) : ua * ub;
         drive8(r, 1'b1, sm, a, b);
         got = 1'b0;
         for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clock);
            cyc++;
            if (done8(r)) begin
               got = 1'b1;
               check($sformatf("w8_r%0d_prod_%0d", r, i), 32'(product8(r)), 32'(exp));
               if (last >= 0) check($sformatf("w8_r%0d_period_%0d", r, i), 32'(cyc - last), 32'(per));
               last = cyc;
            end
         end
         if (!got) begin
            check($sformatf("w8_r%0d_timeout_%0d", r, i), 32'd0, 32'd1);
            break;
         end
      end
      drive8(r, 1'b0, 1'b0, 8'h00, 8'h00);
   endtask

   initial begin
      int nd;
      reset = 1'b1;
      drive4(1'b0, 1'b0, 4'h0, 4'h0);
      drive8(0, 1'b0, 1'b0, 8'h00, 8'h00);
      drive8(1, 1'b0, 1'b0, 8'h00, 8'h00);
      repeat (3) @(negedge clock);
      check("rst_busy_r2", 32'(b4r2.busy), 32'd0);
      check("rst_busy_r4", 32'(b4r4.busy), 32'd0);
      check("rst_done_r2", 32'(b4r2.done), 32'd0);
      check("rst_done_r4", 32'(b4r4.done), 32'd0);
      check("rst_prod_r2", 32'(b4r2.product), 32'd0);
      check("rst_prod_r4", 32'(b4r4.product), 32'd0);
      reset = 1'b0;

      run4("u_12x11",  1'b0, 4'b1100, 4'b1011, 8'h84, 1'b0);
      run4("s_m4xm5",  1'b1, 4'b1100, 4'b1011, 8'h14, 1'b0);
      run4("s_m8xm8",  1'b1, 4'b1000, 4'b1000, 8'h40, 1'b0);
      run4("u_15x15",  1'b0, 4'hf,    4'hf,    8'he1, 1'b0);
      run4("s_m8x7",   1'b1, 4'h8,    4'h7,    8'hc8, 1'b0);
      run4("s_m1xm1",  1'b1, 4'hf,    4'hf,    8'h01, 1'b0);
      run4("s_m7x0",   1'b1, 4'h9,    4'h0,    8'h00, 1'b0);
      run4("u_0x13",   1'b0, 4'h0,    4'hd,    8'h00, 1'b0);
      run4("u_5x3_bz", 1'b0, 4'h5,    4'h3,    8'h0f, 1'b1);

      // Abort in the second RUN cycle.
      @(negedge clock);
      drive4(1'b1, 1'b0, 4'hc, 4'hb);
      @(negedge clock);
      drive4(1'b0, 1'b0, 4'hc, 4'hb);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("abort_busy_r2", 32'(b4r2.busy), 32'd0);
      check("abort_busy_r4", 32'(b4r4.busy), 32'd0);
      check("abort_done_r2", 32'(b4r2.done), 32'd0);
      check("abort_done_r4", 32'(b4r4.done), 32'd0);
      check("abort_prod_r2", 32'(b4r2.product), 32'd0);
      check("abort_prod_r4", 32'(b4r4.product), 32'd0);
      nd = 0;
      repeat (8) begin
         @(negedge clock);
         if (b4r2.done || b4r4.done) nd++;
      end
      check("abort_no_done", 32'(nd), 32'd0);
      run4("u_12x11_post", 1'b0, 4'b1100, 4'b1011, 8'h84, 1'b0);

      run8(0);
      run8(1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
